// File: rtl/oled_pkg.sv
// Shared definitions for the OLED serial receiver: opcodes, addressing modes,
// decoder states and opcode classification.
`timescale 1ns/1ps
package oled_pkg;

  localparam logic [7:0] OP_DISP_OFF     = 8'hAE;
  localparam logic [7:0] OP_DISP_ON      = 8'hAF;
  localparam logic [7:0] OP_CONTRAST     = 8'h81;
  localparam logic [7:0] OP_ADDR_MODE    = 8'h20;
  localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] OP_CLK_DIV      = 8'hD5;
  localparam logic [7:0] OP_MUX_RATIO    = 8'hA8;
  localparam logic [7:0] OP_COM_PINS     = 8'hDA;
  localparam logic [7:0] OP_COL_RANGE    = 8'h21;
  localparam logic [7:0] OP_PAGE_RANGE   = 8'h22;
  localparam logic [7:0] OP_SEG_REMAP0   = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP1   = 8'hA1;
  localparam logic [7:0] OP_COM_SCAN_INC = 8'hC0;
  localparam logic [7:0] OP_COM_SCAN_DEC = 8'hC8;
  localparam logic [7:0] OP_START_LINE   = 8'h40;

  localparam logic [1:0] MODE_HORZ = 2'd0;
  localparam logic [1:0] MODE_PAGE = 2'd2;

  typedef enum logic [1:0] {ST_CMD, ST_ARG1, ST_ARG2} dec_state_e;

  typedef enum logic [1:0] {OPC_UNKNOWN, OPC_NOARG, OPC_ONEARG, OPC_TWOARG} op_class_e;

  function automatic op_class_e op_class(input logic [7:0] op);
    op_class_e c;
    c = OPC_UNKNOWN;
    case (op)
      OP_DISP_OFF, OP_DISP_ON, OP_SEG_REMAP0, OP_SEG_REMAP1,
      OP_COM_SCAN_INC, OP_COM_SCAN_DEC, OP_START_LINE:    c = OPC_NOARG;
      OP_CONTRAST, OP_ADDR_MODE, OP_CHARGE_PUMP,
      OP_CLK_DIV, OP_MUX_RATIO, OP_COM_PINS:               c = OPC_ONEARG;
      OP_COL_RANGE, OP_PAGE_RANGE:                         c = OPC_TWOARG;
      default:                                             c = OPC_UNKNOWN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/oled_spi_shift.sv
// Link front end: synchronizes the serial pins, detects SCLK rising edges and
// assembles MSB-first bytes together with the DC level seen on the 8th edge.
`timescale 1ns/1ps
module oled_spi_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sdin,
  input  logic       dc,
  input  logic       res_n_pin,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       res_n
);

  // Each stage carries {RES, DC, SDIN, SCLK}.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_q, byte_d;
  logic       dc_q, dc_d;
  logic       sclk_s, sdin_s, dc_s, res_s, rise_s;

  assign sclk_s = sync_q[SYNC_STAGES-1][0];
  assign sdin_s = sync_q[SYNC_STAGES-1][1];
  assign dc_s   = sync_q[SYNC_STAGES-1][2];
  assign res_s  = sync_q[SYNC_STAGES-1][3];
  assign rise_s = sclk_s & ~sclk_prev_q;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], {res_n_pin, dc, sdin, sclk}};
    sclk_prev_d  = sclk_s;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    dc_d         = dc_q;
    // A link reset throws away any partially received byte.
    if (!res_s) begin
      sr_d      = 8'h00;
      bit_cnt_d = 3'd0;
    end else if (rise_s) begin
      sr_d      = {sr_q[6:0], sdin_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_d       = {sr_q[6:0], sdin_s};
        dc_d         = dc_s;
      end else begin
        byte_valid_d = 1'b0;
      end
    end else begin
      sr_d = sr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= '0;
      sclk_prev_q  <= 1'b0;
      sr_q         <= 8'h00;
      bit_cnt_q    <= 3'd0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      dc_q         <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      sclk_prev_q  <= sclk_prev_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      dc_q         <= dc_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = byte_q;
  assign rx_dc      = dc_q;
  assign res_n      = res_s;

endmodule

// File: rtl/oled_spi_rx.sv
// Display-side receiver: decodes the command subset from received bytes and
// turns data bytes into display-memory writes with column/page auto-advance.
`timescale 1ns/1ps
module oled_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       SDIN,
  input  logic       DC,
  input  logic       RES,
  output logic       mem_we,
  output logic [8:0] mem_adr,
  output logic [7:0] mem_dat,
  output logic       cmd_strobe,
  output logic [7:0] cmd_byte,
  output logic       cmd_err,
  output logic       disp_on,
  output logic [7:0] contrast
);
  import oled_pkg::*;

  logic       byte_valid_s, rx_dc_s, res_n_s;
  logic [7:0] rx_byte_s;

  oled_spi_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .sclk       (SCLK),
    .sdin       (SDIN),
    .dc         (DC),
    .res_n_pin  (RES),
    .byte_valid (byte_valid_s),
    .rx_byte    (rx_byte_s),
    .rx_dc      (rx_dc_s),
    .res_n      (res_n_s)
  );

  dec_state_e state_q, state_d;
  logic [7:0] op_q, op_d, arg1_q, arg1_d;
  logic       two_q, two_d;
  logic [1:0] mode_q, mode_d;
  logic [6:0] col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
  logic [1:0] page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;
  logic       mem_we_q, mem_we_d, cmd_strobe_q, cmd_strobe_d, cmd_err_q, cmd_err_d;
  logic       disp_on_q, disp_on_d;
  logic [8:0] mem_adr_q, mem_adr_d;
  logic [7:0] mem_dat_q, mem_dat_d, cmd_byte_q, cmd_byte_d, contrast_q, contrast_d;
  logic       apply_s, wr_s;
  logic [7:0] apply_a1_s, apply_a2_s;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    two_d        = two_q;
    arg1_d       = arg1_q;
    mode_d       = mode_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_d        = col_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_d       = page_q;
    disp_on_d    = disp_on_q;
    contrast_d   = contrast_q;
    cmd_byte_d   = cmd_byte_q;
    mem_adr_d    = mem_adr_q;
    mem_dat_d    = mem_dat_q;
    mem_we_d     = 1'b0;
    cmd_strobe_d = 1'b0;
    cmd_err_d    = 1'b0;
    apply_s      = 1'b0;
    apply_a1_s   = 8'h00;
    apply_a2_s   = 8'h00;
    wr_s         = 1'b0;

    if (!res_n_s) begin
      state_d      = ST_CMD;
      op_d         = 8'h00;
      two_d        = 1'b0;
      arg1_d       = 8'h00;
      mode_d       = MODE_PAGE;
      col_start_d  = 7'd0;
      col_end_d    = 7'd127;
      col_d        = 7'd0;
      page_start_d = 2'd0;
      page_end_d   = 2'd3;
      page_d       = 2'd0;
      disp_on_d    = 1'b0;
      contrast_d   = 8'h7F;
      cmd_byte_d   = 8'h00;
      mem_adr_d    = 9'd0;
      mem_dat_d    = 8'h00;
    end else if (byte_valid_s) begin
      if (rx_dc_s) begin
        // Data while arguments are pending aborts the command but still writes.
        wr_s    = 1'b1;
        state_d = ST_CMD;
        if (state_q != ST_CMD) begin
          cmd_err_d = 1'b1;
        end else begin
          cmd_err_d = 1'b0;
        end
      end else begin
        case (state_q)
          ST_CMD: begin
            case (op_class(rx_byte_s))
              OPC_NOARG: begin
                cmd_strobe_d = 1'b1;
                cmd_byte_d   = rx_byte_s;
                if (rx_byte_s == OP_DISP_OFF) begin
                  disp_on_d = 1'b0;
                end else if (rx_byte_s == OP_DISP_ON) begin
                  disp_on_d = 1'b1;
                end else begin
                  disp_on_d = disp_on_q;
                end
              end
              OPC_ONEARG: begin
                op_d    = rx_byte_s;
                two_d   = 1'b0;
                state_d = ST_ARG1;
              end
              OPC_TWOARG: begin
                op_d    = rx_byte_s;
                two_d   = 1'b1;
                state_d = ST_ARG1;
              end
              default: cmd_err_d = 1'b1;
            endcase
          end
          ST_ARG1: begin
            if (two_q) begin
              arg1_d  = rx_byte_s;
              state_d = ST_ARG2;
            end else begin
              apply_s    = 1'b1;
              apply_a1_s = rx_byte_s;
              state_d    = ST_CMD;
            end
          end
          ST_ARG2: begin
            apply_s    = 1'b1;
            apply_a1_s = arg1_q;
            apply_a2_s = rx_byte_s;
            state_d    = ST_CMD;
          end
          default: state_d = ST_CMD;
        endcase
      end
    end else begin
      state_d = state_q;
    end

    if (apply_s) begin
      cmd_strobe_d = 1'b1;
      cmd_byte_d   = op_q;
      case (op_q)
        OP_CONTRAST:  contrast_d = apply_a1_s;
        OP_ADDR_MODE: mode_d     = apply_a1_s[1:0];
        OP_COL_RANGE: begin
          col_start_d = apply_a1_s[6:0];
          col_end_d   = apply_a2_s[6:0];
          col_d       = apply_a1_s[6:0];
        end
        OP_PAGE_RANGE: begin
          page_start_d = apply_a1_s[1:0];
          page_end_d   = apply_a2_s[1:0];
          page_d       = apply_a1_s[1:0];
        end
        default: contrast_d = contrast_q;
      endcase
    end else begin
      cmd_strobe_d = cmd_strobe_d;
    end

    // Only page mode (2) keeps the page fixed; every other mode advances it.
    if (wr_s) begin
      mem_we_d  = 1'b1;
      mem_adr_d = {page_q, col_q};
      mem_dat_d = rx_byte_s;
      if (col_q == col_end_q) begin
        col_d = col_start_q;
        if (mode_q != MODE_PAGE) begin
          page_d = (page_q == page_end_q) ? page_start_q : page_q + 2'd1;
        end else begin
          page_d = page_q;
        end
      end else begin
        col_d = col_q + 7'd1;
      end
    end else begin
      mem_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_CMD;
      op_q         <= 8'h00;
      two_q        <= 1'b0;
      arg1_q       <= 8'h00;
      mode_q       <= MODE_PAGE;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      col_q        <= 7'd0;
      page_start_q <= 2'd0;
      page_end_q   <= 2'd3;
      page_q       <= 2'd0;
      disp_on_q    <= 1'b0;
      contrast_q   <= 8'h7F;
      cmd_byte_q   <= 8'h00;
      mem_adr_q    <= 9'd0;
      mem_dat_q    <= 8'h00;
      mem_we_q     <= 1'b0;
      cmd_strobe_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      two_q        <= two_d;
      arg1_q       <= arg1_d;
      mode_q       <= mode_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_q        <= col_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_q       <= page_d;
      disp_on_q    <= disp_on_d;
      contrast_q   <= contrast_d;
      cmd_byte_q   <= cmd_byte_d;
      mem_adr_q    <= mem_adr_d;
      mem_dat_q    <= mem_dat_d;
      mem_we_q     <= mem_we_d;
      cmd_strobe_q <= cmd_strobe_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_adr    = mem_adr_q;
  assign mem_dat    = mem_dat_q;
  assign cmd_strobe = cmd_strobe_q;
  assign cmd_byte   = cmd_byte_q;
  assign cmd_err    = cmd_err_q;
  assign disp_on    = disp_on_q;
  assign contrast   = contrast_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scoreboard bench for oled_spi_rx: byte-level reference model feeds an
// expectation queue that a monitor drains whenever the DUT emits a strobe.
`timescale 1ns/1ps
module tb_oled_spi_rx;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst, SCLK, SDIN, DC, RES;
  logic       mem_we, cmd_strobe, cmd_err, disp_on;
  logic [8:0] mem_adr;
  logic [7:0] mem_dat, cmd_byte, contrast;

  oled_spi_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .SDIN(SDIN), .DC(DC), .RES(RES),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_dat(mem_dat),
    .cmd_strobe(cmd_strobe), .cmd_byte(cmd_byte), .cmd_err(cmd_err),
    .disp_on(disp_on), .contrast(contrast)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int we; int adr; int dat; int st; int cb; int err; int don; int con; int cyc;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_don, m_con, m_mode, m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_op, m_need;
  int m_args[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_don = 0; m_con = 'h7F; m_mode = 2; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 3;
    m_col = 0; m_page = 0; m_op = 0; m_need = 0; m_args.delete();
  endtask

  task automatic push(input int we, input int adr, input int dat, input int st,
                      input int cb, input int err, input int t);
    ev_t e;
    e.we = we; e.adr = adr; e.dat = dat; e.st = st; e.cb = cb; e.err = err;
    e.don = m_don; e.con = m_con; e.cyc = t + SYNC_STAGES + 2;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input int b, input logic dcv, input int t);
    if (dcv) begin
      int adr, aborted;
      adr = m_page * 128 + m_col;
      aborted = (m_need != 0) ? 1 : 0;
      m_need = 0; m_args.delete();
      if (m_col == m_ce) begin
        m_col = m_cs;
        if (m_mode != 2) m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 4;
      end else begin
        m_col = (m_col + 1) % 128;
      end
      push(1, adr, b, 0, 0, aborted, t);
    end else if (m_need == 0) begin
      case (b)
        'hAE: begin m_don = 0; push(0, 0, 0, 1, b, 0, t); end
        'hAF: begin m_don = 1; push(0, 0, 0, 1, b, 0, t); end
        'hA0, 'hA1, 'hC0, 'hC8, 'h40: push(0, 0, 0, 1, b, 0, t);
        'h81, 'h20, 'h8D, 'hD5, 'hA8, 'hDA: begin m_op = b; m_need = 1; end
        'h21, 'h22: begin m_op = b; m_need = 2; end
        default: push(0, 0, 0, 0, 0, 1, t);
      endcase
    end else begin
      m_args.push_back(b);
      if (m_args.size() == m_need) begin
        case (m_op)
          'h81: m_con = m_args[0];
          'h20: m_mode = m_args[0] % 4;
          'h21: begin m_cs = m_args[0] % 128; m_ce = m_args[1] % 128; m_col = m_cs; end
          'h22: begin m_ps = m_args[0] % 4; m_pe = m_args[1] % 4; m_page = m_ps; end
          default: ;
        endcase
        push(0, 0, 0, 1, m_op, 0, t);
        m_need = 0; m_args.delete();
      end
    end
  endtask

  // Sends n MSB-first bits; only a full byte reaches the model.
  task automatic send_bits(input logic [7:0] b, input logic dcv, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk); SCLK = 1'b0; SDIN = b[i]; DC = dcv;
      repeat (2) @(negedge clk);
      SCLK = 1'b1;
      if (i == 0) model_byte(int'(b), dcv, cyc);
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dcv);
    send_bits(b, dcv, 8);
  endtask

  task automatic res_pulse();
    repeat (8) @(negedge clk);
    RES = 1'b0;
    repeat (4) @(negedge clk);
    RES = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] ops [16] = '{8'hAE, 8'hAF, 8'h81, 8'h20, 8'h8D, 8'hD5, 8'hA8, 8'hDA,
                           8'h21, 8'h22, 8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'h40, 8'h55};

  initial begin
    rst = 1'b0; SCLK = 1'b0; SDIN = 1'b0; DC = 1'b0; RES = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_dat", mem_dat, 0);
    check("rst_cmd_strobe", cmd_strobe, 0);
    check("rst_cmd_byte", cmd_byte, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_disp_on", disp_on, 0);
    check("rst_contrast", contrast, 'h7F);
    repeat (4) @(negedge clk);

    fork
      forever begin
        ev_t e;
        @(negedge clk);
        if (mem_we === 1'b1 || cmd_strobe === 1'b1 || cmd_err === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: we=%0b strobe=%0b err=%0b adr=0x%0h, required no output",
                     mem_we, cmd_strobe, cmd_err, mem_adr);
          end else begin
            e = exp_q.pop_front();
            check("latency", cyc, e.cyc);
            check("mem_we", mem_we, e.we);
            check("cmd_strobe", cmd_strobe, e.st);
            check("cmd_err", cmd_err, e.err);
            if (e.we != 0) begin
              check("mem_adr", mem_adr, e.adr);
              check("mem_dat", mem_dat, e.dat);
            end
            if (e.st != 0) check("cmd_byte", cmd_byte, e.cb);
            check("disp_on", disp_on, e.don);
            check("contrast", contrast, e.con);
          end
        end
      end
    join_none

    // Directed sequences
    send_byte(8'hAF, 1'b0);
    send_byte(8'h81, 1'b0); send_byte(8'h3C, 1'b0);
    send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h21, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h7F, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 1'b1);
    res_pulse();
    for (int i = 0; i < 129; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    res_pulse();
    send_byte(8'h81, 1'b0); send_byte(8'hAA, 1'b1);
    res_pulse();
    send_bits(8'hB5, 1'b0, 5);
    res_pulse();
    send_byte(8'hAE, 1'b0);
    send_byte(8'h55, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 59) == 0) res_pulse();
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 255)), 1'b1);
      else if ($urandom_range(0, 4) == 0) send_byte(8'($urandom_range(0, 255)), 1'b0);
      else send_byte(ops[$urandom_range(0, 15)], 1'b0);
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_disp_on", disp_on, m_don);
    check("final_contrast", contrast, m_con);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
